// File: rtl/mem_tester_pkg.sv
// Shared constants and state encoding for the march-style memory tester.
package mem_tester_pkg;

    // Tester sequence: two write/read passes (true pattern, then complement).
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR_A = 3'd1,
        ST_RD_A = 3'd2,
        ST_WR_B = 3'd3,
        ST_RD_B = 3'd4,
        ST_FIN  = 3'd5
    } state_e;

    // Addresses visited per write or read phase.
    localparam int PHASE_LEN = 32;

    // Cycles between presenting a read address and seeing its data.
    localparam int RD_DRAIN  = 1;

endpackage

// File: rtl/mem_tester_if.sv
// Bus between the tester (master) and the memory under test (slave).
interface mem_tester_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic [AW-1:0] mem_ad;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;

    modport master (
        output mem_ad,
        output mem_din,
        output mem_we,
        input  mem_dout
    );

    modport slave (
        input  mem_ad,
        input  mem_din,
        input  mem_we,
        output mem_dout
    );
endinterface

// File: rtl/mem_tester_pattern.sv
// Expected-data generator: seed + address, optionally complemented.
// Shared by the write path and the read-compare path so both agree.
module mem_pattern #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_seed,
    input  logic [AW-1:0] i_ad,
    input  logic          i_phase_b,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0] w_pat;

    // Sum wraps modulo 2**DW; phase B stores the bitwise complement.
    always_comb begin
        w_pat = i_seed + DW'(i_ad);
        if (i_phase_b) begin
            o_data = ~w_pat;
        end else begin
            o_data = w_pat;
        end
    end

endmodule

// File: rtl/mem_tester.sv
// Memory tester: writes pattern A, reads it back, writes ~A, reads it back,
// counting mismatches and remembering the first failing address.
module mem_tester
    import mem_tester_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [DW-1:0]   seed,
    mem_tester_if.master    mem,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [AW+1:0]   err_cnt,
    output logic [AW-1:0]   first_err_ad
);

    localparam logic [AW-1:0] LAST_AD = AW'(PHASE_LEN - 1);
    localparam logic [AW-1:0] ZERO_AD = {AW{1'b0}};
    localparam logic [AW+1:0] ERR_MAX = {(AW+2){1'b1}};
    localparam logic [AW+1:0] ERR_0   = {(AW+2){1'b0}};

    state_e          r_state;
    state_e          w_nxt_state;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_nxt_cnt;
    logic            r_drain;
    logic            w_nxt_drain;
    logic [DW-1:0]   r_seed;
    logic [DW-1:0]   w_seed_eff;
    logic            w_start_acc;

    logic            w_wr_phase;
    logic            w_rd_phase;
    logic            w_wr_phase_b;
    logic [DW-1:0]   w_wr_data;
    logic            w_cmp_vld;
    logic [AW-1:0]   w_cmp_ad;
    logic [DW-1:0]   w_exp_data;
    logic            w_mismatch;

    logic [AW+1:0]   r_err_cnt;
    logic [AW+1:0]   w_err_nxt;
    logic [AW-1:0]   r_first_err_ad;
    logic [AW-1:0]   w_first_nxt;

    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_ad;
    logic [DW-1:0]   r_mem_din;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_seed_eff  = w_start_acc ? seed : r_seed;

    // State, address counter and read-drain flag.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= ZERO_AD;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_drain <= w_nxt_drain;
        end
    end

    // Next-state sequencing; counter stops at the terminal address, never wraps.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_drain = r_drain;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nxt_state = ST_WR_A;
                    w_nxt_cnt   = ZERO_AD;
                    w_nxt_drain = 1'b0;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_WR_A, ST_WR_B: begin
                if (r_cnt == LAST_AD) begin
                    w_nxt_state = (r_state == ST_WR_A) ? ST_RD_A : ST_RD_B;
                    w_nxt_cnt   = ZERO_AD;
                end else begin
                    w_nxt_cnt   = r_cnt + AW'(1);
                end
            end
            ST_RD_A, ST_RD_B: begin
                if (r_drain) begin
                    w_nxt_state = (r_state == ST_RD_A) ? ST_WR_B : ST_FIN;
                    w_nxt_cnt   = ZERO_AD;
                    w_nxt_drain = 1'b0;
                end else if (r_cnt == LAST_AD) begin
                    w_nxt_drain = 1'b1;
                end else begin
                    w_nxt_cnt   = r_cnt + AW'(1);
                end
            end
            ST_FIN: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = ZERO_AD;
                w_nxt_drain = 1'b0;
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = ZERO_AD;
                w_nxt_drain = 1'b0;
            end
        endcase
    end

    // Bus outputs are registered from next state, so they line up with the state cycle.
    assign w_wr_phase   = (w_nxt_state == ST_WR_A) || (w_nxt_state == ST_WR_B);
    assign w_rd_phase   = (w_nxt_state == ST_RD_A) || (w_nxt_state == ST_RD_B);
    assign w_wr_phase_b = (w_nxt_state == ST_WR_B);

    mem_pattern #(.AW(AW), .DW(DW)) u_wr_pattern (
        .i_seed    (w_seed_eff),
        .i_ad      (w_nxt_cnt),
        .i_phase_b (w_wr_phase_b),
        .o_data    (w_wr_data)
    );

    // Read data trails the address by one cycle; during the drain cycle the
    // counter is parked on the last address, which is the one being checked.
    assign w_cmp_vld = ((r_state == ST_RD_A) || (r_state == ST_RD_B)) &&
                       (r_drain || (r_cnt != ZERO_AD));
    assign w_cmp_ad  = r_drain ? r_cnt : (r_cnt - AW'(RD_DRAIN));

    mem_pattern #(.AW(AW), .DW(DW)) u_cmp_pattern (
        .i_seed    (r_seed),
        .i_ad      (w_cmp_ad),
        .i_phase_b (r_state == ST_RD_B),
        .o_data    (w_exp_data)
    );

    assign w_mismatch = w_cmp_vld && (mem.mem_dout != w_exp_data);

    // Error bookkeeping: cleared on an accepted start, saturating count, first address latched once.
    always_comb begin
        w_err_nxt   = r_err_cnt;
        w_first_nxt = r_first_err_ad;
        if (w_start_acc) begin
            w_err_nxt   = ERR_0;
            w_first_nxt = ZERO_AD;
        end else if (w_mismatch) begin
            if (r_err_cnt == ERR_MAX) begin
                w_err_nxt = r_err_cnt;
            end else begin
                w_err_nxt = r_err_cnt + {{(AW+1){1'b0}}, 1'b1};
            end
            if (r_err_cnt == ERR_0) begin
                w_first_nxt = w_cmp_ad;
            end else begin
                w_first_nxt = r_first_err_ad;
            end
        end else begin
            w_err_nxt   = r_err_cnt;
            w_first_nxt = r_first_err_ad;
        end
    end

    // Registered outputs, seed capture and result registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_seed         <= {DW{1'b0}};
            r_err_cnt      <= ERR_0;
            r_first_err_ad <= ZERO_AD;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_ad       <= ZERO_AD;
            r_mem_din      <= {DW{1'b0}};
        end else begin
            r_seed         <= w_seed_eff;
            r_err_cnt      <= w_err_nxt;
            r_first_err_ad <= w_first_nxt;
            r_busy         <= (w_nxt_state != ST_IDLE);
            r_done         <= (w_nxt_state == ST_FIN);
            if (w_start_acc) begin
                r_pass <= 1'b0;
            end else if (w_nxt_state == ST_FIN) begin
                r_pass <= (w_err_nxt == ERR_0);
            end else begin
                r_pass <= r_pass;
            end
            r_mem_we  <= w_wr_phase;
            r_mem_ad  <= (w_wr_phase || w_rd_phase) ? w_nxt_cnt : ZERO_AD;
            r_mem_din <= w_wr_phase ? w_wr_data : {DW{1'b0}};
        end
    end

    assign mem.mem_ad    = r_mem_ad;
    assign mem.mem_din   = r_mem_din;
    assign mem.mem_we    = r_mem_we;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign first_err_ad  = r_first_err_ad;

endmodule

// File: tb/tb_mem_tester.sv
// Directed bench for mem_tester with a 32x8 registered-address memory model
// that can inject a stuck-at-0 on bit 3 of address 5.
module tb_mem_tester;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk   = 1'b0;
    logic          clr   = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] seed  = 8'h00;
    logic          fault = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW+1:0] err_cnt;
    logic [AW-1:0] first_err_ad;

    int n_checks = 0;
    int n_errors = 0;

    mem_tester_if #(.AW(AW), .DW(DW)) u_if ();

    mem_tester #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .seed         (seed),
        .mem          (u_if),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_cnt      (err_cnt),
        .first_err_ad (first_err_ad)
    );

    always #5 clk = ~clk;

    // Memory model and write log.
    logic [DW-1:0] mem [0:31];
    logic [AW-1:0] rd_ad;
    logic [DW-1:0] wr_log [0:511];
    int            wr_n = 0;

    always @(posedge clk) begin
        if (u_if.mem_we) begin
            mem[u_if.mem_ad]   <= u_if.mem_din;
            wr_log[wr_n % 512] <= u_if.mem_din;
            wr_n               <= wr_n + 1;
        end
        rd_ad <= u_if.mem_ad;
    end

    assign u_if.mem_dout = (fault && rd_ad == 5'd5) ? (mem[rd_ad] & 8'hF7) : mem[rd_ad];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in WR_A cycle 1; returns the cycle index in which done is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1 clr = 1'b0;
        #2;
        n_checks++;
        if ({busy, done, pass, err_cnt, first_err_ad, u_if.mem_we, u_if.mem_ad, u_if.mem_din} !== 29'd0) begin
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy, done, pass, err_cnt, first_err_ad, u_if.mem_we, u_if.mem_ad, u_if.mem_din});
            n_errors++;
        end
        tick();
        clr = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
            n_errors++;
        end
    endtask

    task automatic test_seed00();
        int base;
        int cyc;
        logic [7:0] a8;
        base = wr_n;
        seed = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL s00_busy_rise: got %b expected 1", busy);
            n_errors++;
        end
        wait_done(cyc);
        n_checks++;
        if (cyc != 131) begin
            $display("FAIL s00_done_cycle: got %0d expected 131", cyc);
            n_errors++;
        end
        n_checks++;
        if (pass !== 1'b1 || err_cnt !== 7'd0 || first_err_ad !== 5'd0) begin
            $display("FAIL s00_result: pass=%b err=%0d first=%0d expected 1 0 0", pass, err_cnt, first_err_ad);
            n_errors++;
        end
        n_checks++;
        if ({u_if.mem_we, u_if.mem_ad, u_if.mem_din} !== 14'd0) begin
            $display("FAIL s00_fin_bus: got %h expected 0", {u_if.mem_we, u_if.mem_ad, u_if.mem_din});
            n_errors++;
        end
        n_checks++;
        if (wr_n - base != 64) begin
            $display("FAIL s00_write_count: got %0d expected 64", wr_n - base);
            n_errors++;
        end
        for (int a = 0; a < 32; a++) begin
            a8 = 8'(a);
            n_checks++;
            if (wr_log[(base + a) % 512] !== a8 || wr_log[(base + 32 + a) % 512] !== ~a8) begin
                $display("FAIL s00_wdata[%0d]: got %h/%h expected %h/%h", a,
                         wr_log[(base + a) % 512], wr_log[(base + 32 + a) % 512], a8, ~a8);
                n_errors++;
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
            $display("FAIL s00_after_done: done=%b busy=%b pass=%b expected 0 0 1", done, busy, pass);
            n_errors++;
        end
    endtask

    task automatic test_seed_wrap();
        int base;
        int cyc;
        base = wr_n;
        seed = 8'hF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc != 131 || pass !== 1'b1) begin
            $display("FAIL wrap_result: cycle=%0d pass=%b expected 131 1", cyc, pass);
            n_errors++;
        end
        n_checks++;
        if (wr_log[base % 512] !== 8'hF0 || wr_log[(base + 31) % 512] !== 8'h0F) begin
            $display("FAIL wrap_a: got %h %h expected f0 0f", wr_log[base % 512], wr_log[(base + 31) % 512]);
            n_errors++;
        end
        n_checks++;
        if (wr_log[(base + 32) % 512] !== 8'h0F || wr_log[(base + 63) % 512] !== 8'hF0) begin
            $display("FAIL wrap_b: got %h %h expected 0f f0", wr_log[(base + 32) % 512], wr_log[(base + 63) % 512]);
            n_errors++;
        end
        tick();
    endtask

    task automatic test_stuck_bit();
        int base;
        int cyc;
        base = wr_n;
        fault = 1'b1;
        seed = 8'h08;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc != 131) begin
            $display("FAIL stuck_done_cycle: got %0d expected 131", cyc);
            n_errors++;
        end
        n_checks++;
        if (err_cnt !== 7'd1 || first_err_ad !== 5'd5 || pass !== 1'b0) begin
            $display("FAIL stuck_result: err=%0d first=%0d pass=%b expected 1 5 0", err_cnt, first_err_ad, pass);
            n_errors++;
        end
        n_checks++;
        if (wr_log[(base + 5) % 512] !== 8'h0D || wr_log[(base + 37) % 512] !== 8'hF2) begin
            $display("FAIL stuck_wdata: got %h %h expected 0d f2", wr_log[(base + 5) % 512], wr_log[(base + 37) % 512]);
            n_errors++;
        end
        tick();
        tick();
        n_checks++;
        if (pass !== 1'b0 || err_cnt !== 7'd1) begin
            $display("FAIL stuck_hold: pass=%b err=%0d expected 0 1", pass, err_cnt);
            n_errors++;
        end
        fault = 1'b0;
    endtask

    task automatic test_clr_abort();
        int cyc;
        fault = 1'b1;
        seed = 8'h08;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 40; i++) tick();
        n_checks++;
        if (busy !== 1'b1 || err_cnt !== 7'd1 || first_err_ad !== 5'd5) begin
            $display("FAIL abort_pre: busy=%b err=%0d first=%0d expected 1 1 5", busy, err_cnt, first_err_ad);
            n_errors++;
        end
        #1 clr = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, pass, err_cnt, first_err_ad, u_if.mem_we, u_if.mem_ad, u_if.mem_din} !== 29'd0) begin
            $display("FAIL abort_async_clear: got %h expected 0",
                     {busy, done, pass, err_cnt, first_err_ad, u_if.mem_we, u_if.mem_ad, u_if.mem_din});
            n_errors++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL abort_hold_%0d: done=%b busy=%b expected 0 0", i, done, busy);
                n_errors++;
            end
        end
        clr = 1'b1;
        fault = 1'b0;
        tick();
        seed = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc != 131 || pass !== 1'b1 || err_cnt !== 7'd0) begin
            $display("FAIL abort_rerun: cycle=%0d pass=%b err=%0d expected 131 1 0", cyc, pass, err_cnt);
            n_errors++;
        end
        tick();
    endtask

    task automatic test_start_held();
        int cyc;
        seed = 8'h55;
        start = 1'b1;
        tick();
        wait_done(cyc);
        n_checks++;
        if (cyc != 131 || pass !== 1'b1) begin
            $display("FAIL held_first: cycle=%0d pass=%b expected 131 1", cyc, pass);
            n_errors++;
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL held_idle_gap: busy=%b done=%b expected 0 0", busy, done);
            n_errors++;
        end
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL held_restart: busy=%b expected 1", busy);
            n_errors++;
        end
        start = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc != 131 || pass !== 1'b1) begin
            $display("FAIL held_second: cycle=%0d pass=%b expected 131 1", cyc, pass);
            n_errors++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_seed00();
        test_seed_wrap();
        test_stuck_bit();
        test_clr_abort();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
